// File: rtl/dsram_pkg.sv
// Shared constants, region encoding and byte-merge helper for the data SRAM responder.
// Optional feature macro used by the includers: DSRAM_BYTE_WE_EN.
package dsram_pkg;

   localparam logic [31:0] DEF_RAM_BASE  = 32'h1c00_0000;
   localparam logic [31:0] DEF_CONF_BASE = 32'hbfaf_0000;
   localparam int          DEF_ADDR_W    = 14;

   localparam logic [3:0] CONF_OFS_TIMER   = 4'h0;
   localparam logic [3:0] CONF_OFS_LED     = 4'h4;
   localparam logic [3:0] CONF_OFS_SCRATCH = 4'h8;
   localparam logic [3:0] CONF_OFS_BADCNT  = 4'hC;

   typedef enum logic [1:0] {
      RGN_RAM  = 2'd0,
      RGN_CONF = 2'd1,
      RGN_BAD  = 2'd2
   } region_e;

   // Replace the byte lanes of old_word selected by be with the lanes of new_word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_1rw_sync.sv
// Single-port synchronous RAM, 2**ADDR_W x 32, per-byte write enables.
// Read data register only changes on a read access, so it holds across writes and idle cycles.
module sram_1rw_sync
   import dsram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              cs,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0] mem_r [DEPTH];
   logic [31:0] rdata_r;

   // byte-lane write into the storage array
   always_ff @(posedge clk) begin
      if (cs && we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // synchronous read, held when there is no read access
   always_ff @(posedge clk) begin
      if (cs && !we) begin
         rdata_r <= mem_r[addr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/data_sram_resp.sv
// Data-bus responder: decodes CPU data SRAM requests to a RAM window or a 4-register config block.
// Define DSRAM_BYTE_WE_EN for a 4-bit per-byte-lane data_sram_we; otherwise we is 1 bit, full-word.
module data_sram_resp
   import dsram_pkg::*;
#(
   parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
   parameter int          ADDR_W    = DEF_ADDR_W,
   parameter logic [31:0] CONF_BASE = DEF_CONF_BASE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_en,
`ifdef DSRAM_BYTE_WE_EN
   input  logic [3:0]  data_sram_we,
`else
   input  logic        data_sram_we,
`endif
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   output logic        bad_addr
);

   logic        req_s;
   logic        wr_s;
   logic        rd_s;
   logic [3:0]  be_s;
   region_e     rgn_s;
   logic [3:0]  ofs_s;
   logic        conf_wr_s;
   logic        bad_req_s;
   logic [31:0] conf_rd_s;
   logic [15:0] led_new_s;
   logic [31:0] scratch_new_s;
   logic [31:0] ram_q_s;
   logic        unused_addr_bits_s;

   logic [31:0] timer_r;
   logic [15:0] led_r;
   logic [31:0] scratch_r;
   logic [7:0]  badcnt_r;
   logic        bad_addr_r;
   region_e     rsel_r;
   logic [31:0] conf_q_r;

   assign unused_addr_bits_s = ^data_sram_addr[1:0];

   // request qualification and address decode; a request during reset is dropped
   always_comb begin
      req_s = data_sram_en && !reset;
`ifdef DSRAM_BYTE_WE_EN
      be_s  = data_sram_we;
`else
      be_s  = {4{data_sram_we}};
`endif
      wr_s  = req_s && (be_s != 4'h0);
      rd_s  = req_s && (be_s == 4'h0);
      if ((data_sram_addr >> (ADDR_W + 2)) == (RAM_BASE >> (ADDR_W + 2))) begin
         rgn_s = RGN_RAM;
      end else if (data_sram_addr[31:4] == CONF_BASE[31:4]) begin
         rgn_s = RGN_CONF;
      end else begin
         rgn_s = RGN_BAD;
      end
      ofs_s     = {data_sram_addr[3:2], 2'b00};
      conf_wr_s = wr_s && (rgn_s == RGN_CONF);
      bad_req_s = req_s && (rgn_s == RGN_BAD);
   end

   // config register read mux and lane-merged write values
   always_comb begin
      case (ofs_s)
         CONF_OFS_TIMER:   conf_rd_s = timer_r;
         CONF_OFS_LED:     conf_rd_s = {16'h0000, led_r};
         CONF_OFS_SCRATCH: conf_rd_s = scratch_r;
         CONF_OFS_BADCNT:  conf_rd_s = {24'h00_0000, badcnt_r};
         default:          conf_rd_s = 32'h0000_0000;
      endcase
      scratch_new_s = merge_bytes(scratch_r, data_sram_wdata, be_s);
      led_new_s     = led_r;
      for (int i = 0; i < 2; i++) begin
         if (be_s[i]) begin
            led_new_s[8*i +: 8] = data_sram_wdata[8*i +: 8];
         end else begin
            led_new_s[8*i +: 8] = led_r[8*i +: 8];
         end
      end
   end

   sram_1rw_sync #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .cs    (req_s && (rgn_s == RGN_RAM)),
      .we    (wr_s),
      .be    (be_s),
      .addr  (data_sram_addr[ADDR_W+1:2]),
      .wdata (data_sram_wdata),
      .rdata (ram_q_s)
   );

   // config registers, bad-address tracking and registered read select
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_r    <= 32'h0000_0000;
         led_r      <= 16'h0000;
         scratch_r  <= 32'h0000_0000;
         badcnt_r   <= 8'h00;
         bad_addr_r <= 1'b0;
         rsel_r     <= RGN_BAD;
         conf_q_r   <= 32'h0000_0000;
      end else begin
         // a timer load below overrides this increment
         timer_r    <= timer_r + 32'd1;
         bad_addr_r <= bad_req_s;
         if (conf_wr_s) begin
            case (ofs_s)
               CONF_OFS_TIMER:   timer_r   <= data_sram_wdata;
               CONF_OFS_LED:     led_r     <= led_new_s;
               CONF_OFS_SCRATCH: scratch_r <= scratch_new_s;
               CONF_OFS_BADCNT:  badcnt_r  <= 8'h00;
               default:          timer_r   <= timer_r + 32'd1;
            endcase
         end
         if (bad_req_s && (badcnt_r != 8'hff)) begin
            badcnt_r <= badcnt_r + 8'd1;
         end
         if (rd_s) begin
            rsel_r <= rgn_s;
         end
         if (rd_s && (rgn_s == RGN_CONF)) begin
            conf_q_r <= conf_rd_s;
         end
      end
   end

   // read data follows the region captured at the last read; BAD reads return zero
   always_comb begin
      case (rsel_r)
         RGN_RAM:  data_sram_rdata = ram_q_s;
         RGN_CONF: data_sram_rdata = conf_q_r;
         default:  data_sram_rdata = 32'h0000_0000;
      endcase
   end

   assign led      = led_r;
   assign bad_addr = bad_addr_r;

endmodule

// File: tb/tb_data_sram_resp.sv
// Randomised bench for data_sram_resp with an address-range based reference model.
// Build with DSRAM_BYTE_WE_EN defined to exercise byte-lane writes.
module tb_data_sram_resp;

   localparam logic [31:0] RAMB  = 32'h1c00_0000;
   localparam logic [31:0] CONFB = 32'hbfaf_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        data_sram_en;
`ifdef DSRAM_BYTE_WE_EN
   logic [3:0]  data_sram_we;
`else
   logic        data_sram_we;
`endif
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [15:0] led;
   logic        bad_addr;

   data_sram_resp dut (
      .clk             (clk),
      .reset           (reset),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .led             (led),
      .bad_addr        (bad_addr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   // reference model state
   logic [31:0] mem [int unsigned];
   logic [31:0] m_timer;
   logic [15:0] m_led;
   logic [31:0] m_scratch;
   logic [7:0]  m_badcnt;
   logic [31:0] exp_rdata;
   logic        exp_bad;
   bit          rd_known;
   int unsigned pool [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] eff_mask(input logic [3:0] we);
`ifdef DSRAM_BYTE_WE_EN
      return we;
`else
      return (we != 4'h0) ? 4'hf : 4'h0;
`endif
   endfunction

   task automatic model(input logic rst, input logic en, input logic [3:0] we,
                        input logic [31:0] a, input logic [31:0] wd);
      logic [3:0]  m;
      logic [31:0] old_t;
      logic [31:0] w;
      int unsigned idx;
      if (rst) begin
         m_timer = 32'h0; m_led = 16'h0; m_scratch = 32'h0; m_badcnt = 8'h0;
         exp_rdata = 32'h0; exp_bad = 1'b0; rd_known = 1'b1;
         return;
      end
      m = eff_mask(we);
      old_t = m_timer;
      m_timer = m_timer + 32'd1;
      exp_bad = 1'b0;
      if (!en) return;
      if (a >= RAMB && a < RAMB + 32'h0001_0000) begin
         idx = (a - RAMB) / 4;
         if (m != 4'h0) begin
            if (mem.exists(idx) || m == 4'hf) begin
               w = mem.exists(idx) ? mem[idx] : 32'h0;
               for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = wd[8*i +: 8];
               mem[idx] = w;
            end
         end else if (mem.exists(idx)) begin
            exp_rdata = mem[idx]; rd_known = 1'b1;
         end else begin
            rd_known = 1'b0;
         end
      end else if (a >= CONFB && a < CONFB + 32'h10) begin
         idx = (a - CONFB) / 4;
         if (m != 4'h0) begin
            case (idx)
               0: m_timer = wd;
               1: for (int i = 0; i < 2; i++) if (m[i]) m_led[8*i +: 8] = wd[8*i +: 8];
               2: for (int i = 0; i < 4; i++) if (m[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
               default: m_badcnt = 8'h0;
            endcase
         end else begin
            case (idx)
               0: exp_rdata = old_t;
               1: exp_rdata = {16'h0, m_led};
               2: exp_rdata = m_scratch;
               default: exp_rdata = {24'h0, m_badcnt};
            endcase
            rd_known = 1'b1;
         end
      end else begin
         exp_bad = 1'b1;
         if (m_badcnt != 8'hff) m_badcnt = m_badcnt + 8'd1;
         if (m == 4'h0) begin
            exp_rdata = 32'h0; rd_known = 1'b1;
         end
      end
   endtask

   task automatic step(input logic rst, input logic en, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      reset = rst;
      data_sram_en = en;
`ifdef DSRAM_BYTE_WE_EN
      data_sram_we = we;
`else
      data_sram_we = (we != 4'h0);
`endif
      data_sram_addr = a;
      data_sram_wdata = wd;
      @(posedge clk);
      #1;
      model(rst, en, we, a, wd);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] wd);
      step(1'b0, 1'b1, 4'hf, a, wd);
   endtask

   task automatic rd(input logic [31:0] a);
      step(1'b0, 1'b1, 4'h0, a, $urandom());
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'(($urandom() & 32'h1) * 15), $urandom(), $urandom());
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_on) begin
         if (rd_known) chk("rdata", data_sram_rdata, exp_rdata);
         chk("led", {16'h0, led}, {16'h0, m_led});
         chk("bad_addr", {31'h0, bad_addr}, {31'h0, exp_bad});
      end
   end

   initial begin
      logic [31:0] a;
      logic [3:0]  we;
      int          kind;
      rd_known = 1'b0;
      step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      step(1'b1, 1'b1, 4'hf, RAMB, 32'h1234_5678);
      chk_on = 1'b1;
      chk("reset_rdata", data_sram_rdata, 32'h0);
      chk("reset_led", {16'h0, led}, 32'h0);
      chk("reset_bad", {31'h0, bad_addr}, 32'h0);

      // test 1/2: basic RAM access, ignored low address bits, last word
      wr(32'h1c00_0010, 32'hdead_beef);
      rd(32'h1c00_0010);
      chk("ram_read", data_sram_rdata, 32'hdead_beef);
      idle();
      chk("rdata_hold", data_sram_rdata, 32'hdead_beef);
      rd(32'h1c00_0013);
      chk("ram_lowbits", data_sram_rdata, 32'hdead_beef);
      wr(32'h1c00_fffc, 32'hcafe_f00d);
      rd(32'h1c00_fffc);
      chk("ram_last", data_sram_rdata, 32'hcafe_f00d);

      // test 3: timer load and wrap
      wr(CONFB, 32'h0000_0100);
      repeat (5) idle();
      rd(CONFB);
      chk("timer_load", data_sram_rdata, 32'h0000_0105);
      wr(CONFB, 32'hffff_ffff);
      rd(CONFB);
      chk("timer_max", data_sram_rdata, 32'hffff_ffff);
      rd(CONFB);
      chk("timer_wrap", data_sram_rdata, 32'h0);

      // test 4: bad address and saturating counter
      wr(CONFB + 32'hc, 32'h5a5a_5a5a);
      rd(32'h0000_0000);
      chk("bad_rdata", data_sram_rdata, 32'h0);
      chk("bad_pulse", {31'h0, bad_addr}, 32'h1);
      rd(CONFB + 32'hc);
      chk("bad_pulse_end", {31'h0, bad_addr}, 32'h0);
      chk("badcnt_1", data_sram_rdata, 32'h1);
      repeat (256) rd(32'h0000_0040);
      rd(CONFB + 32'hc);
      chk("badcnt_sat", data_sram_rdata, 32'h0000_00ff);
      wr(CONFB + 32'hc, 32'hffff_ffff);
      rd(CONFB + 32'hc);
      chk("badcnt_clr", data_sram_rdata, 32'h0);

      // test 5: led and reset mid-stream
      wr(CONFB + 32'h4, 32'hffff_a5a5);
      chk("led_write", {16'h0, led}, 32'h0000_a5a5);
      rd(CONFB + 32'h4);
      chk("led_read", data_sram_rdata, 32'h0000_a5a5);
      step(1'b1, 1'b1, 4'hf, CONFB + 32'h4, 32'h0000_1111);
      chk("rst_led", {16'h0, led}, 32'h0);
      chk("rst_rdata", data_sram_rdata, 32'h0);

`ifdef DSRAM_BYTE_WE_EN
      // test 6: byte lanes
      wr(32'h1c00_0020, 32'h1122_3344);
      step(1'b0, 1'b1, 4'b0101, 32'h1c00_0020, 32'haabb_ccdd);
      rd(32'h1c00_0020);
      chk("byte_we", data_sram_rdata, 32'h11bb_33dd);
`endif

      // random phase over a pre-written pool of RAM words
      pool[0] = 0; pool[1] = 4; pool[2] = 16383;
      for (int i = 3; i < 16; i++) pool[i] = $urandom_range(0, 16383);
      for (int i = 0; i < 16; i++) wr(RAMB + 32'(pool[i] * 4), $urandom());
      for (int n = 0; n < 3000; n++) begin
         kind = $urandom_range(0, 9);
         if (kind < 5) a = RAMB + 32'(pool[$urandom_range(0, 15)] * 4) + 32'($urandom_range(0, 3));
         else if (kind < 8) a = CONFB + 32'($urandom_range(0, 15));
         else a = $urandom();
`ifdef DSRAM_BYTE_WE_EN
         we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
`else
         we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hf;
`endif
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) != 0), we, a, $urandom());
      end

      @(negedge clk);
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
